// File: rtl/tx_buffer.sv
// tx_buffer: store-and-forward transmit byte FIFO replaying frames on AXI-S.
// Define TX_BUFFER_FRAME_CNT_EN to add tx_frame_cnt and tx_drop_cnt outputs.
module tx_buffer #(
   parameter int SIZE       = 2048,
   parameter int IFG_CYCLES = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btx_valid,
   input  logic                  btx_last,
   input  logic [7:0]            t_data,
   output logic                  btx_full,
   output logic                  btx_empty,
   output logic                  btx_overflow,
   output logic [$clog2(SIZE):0] btx_frames,
   output logic [7:0]            tx_tdata,
   output logic                  tx_tvalid,
   output logic                  tx_tlast,
   input  logic                  tx_tready
`ifdef TX_BUFFER_FRAME_CNT_EN
   ,
   output logic [31:0]           tx_frame_cnt,
   output logic [15:0]           tx_drop_cnt
`endif
);

   localparam int AW = $clog2(SIZE);
   localparam int FW = AW + 1;
   localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_e;

   logic [8:0]    mem_q [SIZE];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [FW-1:0] frames_q, frames_d;
   logic          ovf_q;
   state_e        state_q;
   logic [GW-1:0] gap_q;
   logic [7:0]    tdata_q;
   logic          tvalid_q;
   logic          tlast_q;

   logic          wr_en;
   logic          rd_en;
   logic          hs;
   logic          eof_in;
   logic          eof_out;
   logic          start;
   logic [8:0]    rd_word;

   assign btx_full  = (wptr_q + AW'(1)) == rptr_q;
   assign btx_empty = wptr_q == rptr_q;
   assign wr_en     = btx_valid & ~btx_full;
   assign hs        = tvalid_q & tx_tready;
   assign eof_in    = wr_en & btx_last;
   assign eof_out   = hs & tlast_q;
   assign rd_word   = mem_q[rptr_q];

   // A full buffer with no complete frame would deadlock; stream it out anyway.
   assign start = (frames_q != '0) | (btx_full & (frames_q == '0));

   always_comb begin
      rd_en = 1'b0;
      unique case (state_q)
         IDLE:    rd_en = start;
         SEND:    rd_en = ~eof_out & (hs | ~tvalid_q) & ~btx_empty;
         default: rd_en = 1'b0;
      endcase
   end

   always_comb begin
      wptr_d   = wptr_q + AW'(wr_en);
      rptr_d   = rptr_q + AW'(rd_en);
      frames_d = frames_q;
      if (eof_in & ~eof_out) begin
         frames_d = frames_q + FW'(1);
      end else if (~eof_in & eof_out) begin
         frames_d = frames_q - FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= {btx_last, t_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         frames_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         frames_q <= frames_d;
         ovf_q    <= btx_valid & btx_full;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         if (rd_en) begin
            tvalid_q <= 1'b1;
            tdata_q  <= rd_word[7:0];
            tlast_q  <= rd_word[8];
         end
         unique case (state_q)
            IDLE: begin
               if (start) state_q <= SEND;
            end
            SEND: begin
               if (eof_out) begin
                  tvalid_q <= 1'b0;
                  tlast_q  <= 1'b0;
                  if (IFG_CYCLES == 0) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= GAP;
                     gap_q   <= GW'(IFG_CYCLES);
                  end
               end else if (hs & btx_empty) begin
                  tvalid_q <= 1'b0;
               end
            end
            GAP: begin
               gap_q <= gap_q - GW'(1);
               if (gap_q == GW'(1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign btx_frames   = frames_q;
   assign btx_overflow = ovf_q;
   assign tx_tdata     = tdata_q;
   assign tx_tvalid    = tvalid_q;
   assign tx_tlast     = tlast_q;

`ifdef TX_BUFFER_FRAME_CNT_EN
   logic [31:0] fcnt_q;
   logic [15:0] dcnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt_q <= '0;
         dcnt_q <= '0;
      end else begin
         if (eof_out) fcnt_q <= fcnt_q + 32'd1;
         if (ovf_q && (dcnt_q != 16'hFFFF)) dcnt_q <= dcnt_q + 16'd1;
      end
   end

   assign tx_frame_cnt = fcnt_q;
   assign tx_drop_cnt  = dcnt_q;
`endif

endmodule

// File: doc/tx_buffer.md
Name: tx_buffer

Overview:
- Transmit-side byte FIFO for the pattern-generator MAC datapath, the mirror of the receive buffer.
- Accepts bytes plus an end-of-frame flag from the message source and stores whole frames (store-and-forward).
- Replays each frame as an AXI-Stream byte stream to the tri-mode MAC TX interface.
- Enforces a programmable idle gap between frames.

Parameters:
- SIZE, 2048, storage depth in entries; power of two; usable capacity SIZE-1 bytes.
- IFG_CYCLES, 12, idle cycles inserted after each frame's tlast handshake; 0 allowed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- btx_valid  in  1  write strobe from source
- btx_last  in  1  marks the written byte as the last of its frame
- t_data  in  8  write byte
- btx_full  out  1  storage full
- btx_empty  out  1  storage empty (excludes the output register)
- btx_overflow  out  1  one-cycle pulse: write attempted while full, byte dropped
- btx_frames  out  $clog2(SIZE)+1  complete frames currently stored
- tx_tdata  out  8  AXI-S data to MAC
- tx_tvalid  out  1  AXI-S valid
- tx_tlast  out  1  AXI-S last
- tx_tready  in  1  AXI-S ready from MAC

Behaviour:
- Single clock domain; clk and rst only. Reset is synchronous and active-high on all state.
- Reset values: wptr=rptr=0, btx_full=0, btx_empty=1, btx_overflow=0, btx_frames=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0, FSM in IDLE, gap counter 0.
- Storage: SIZE x 9-bit entries {last, data}. Pointers are $clog2(SIZE) bits and wrap naturally.
  - full = (wptr+1 == rptr); empty = (wptr == rptr). Both are combinational from the registered pointers.
- Write: accepted when btx_valid & !btx_full; stores {btx_last, t_data} at wptr, then wptr++.
  - If btx_valid & btx_full: the byte is not stored, the pointer is unchanged, and btx_overflow pulses the next cycle.
- btx_frames: +1 on an accepted write with btx_last; -1 on a tx handshake with tx_tlast. Both in the same cycle leaves it unchanged.
- Handshake: beat transfers when tx_tvalid & tx_tready. While tx_tvalid=1 & tx_tready=0, tx_tdata and tx_tlast hold stable. tx_tvalid never drops without a handshake.
- FSM states: IDLE, SEND, GAP.
  - IDLE: tx_tvalid=0.
    - Start condition: btx_frames!=0, or (btx_full & btx_frames==0), the oversize-frame fallback that prevents deadlock.
    - On start: the output register loads buffer[rptr], rptr++, tx_tvalid=1 the next cycle, go to SEND.
  - SEND, on handshake:
    - tx_tlast=1: tx_tvalid=0 next cycle. Go to GAP with counter=IFG_CYCLES, or to IDLE if IFG_CYCLES=0.
    - Else if !btx_empty: load the next entry, rptr++, tx_tvalid stays 1. Back-to-back beats at full rate.
    - Else (fallback mode only): tx_tvalid=0. Stay in SEND and load as soon as !btx_empty.
  - GAP: the counter decrements each cycle; at 1 go to IDLE. tx_tvalid=0 throughout.
- Latency: accepted write of a frame's last byte in cycle N → btx_frames updated N+1 → tx_tvalid=1 in cycle N+2, with an empty pipeline and FSM in IDLE.
- Simultaneous write and read in one cycle are both honored; full and empty are computed from the pre-update pointers.
- Reset mid-frame: the frame is discarded, no tlast is emitted, and buffer contents are abandoned.

Optional Feature:
- Macro: TX_BUFFER_FRAME_CNT_EN.
- Defined:
  - Adds output tx_frame_cnt (32 bits), reset to 0.
  - Increments by 1 on every tx handshake with tx_tlast=1, wrapping at 2^32.
  - Adds output tx_drop_cnt (16 bits), reset to 0, incrementing on each btx_overflow pulse and saturating at 0xFFFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles → btx_empty=1, btx_full=0, btx_frames=0, tx_tvalid=0, btx_overflow=0.
- Single frame: write 0x11,0x22,0x33,0x44 (btx_last on 0x44), tx_tready=1 → tx_tvalid rises 2 cycles after the 0x44 write; 4 consecutive beats; tx_tlast only with 0x44; then 12 cycles of tx_tvalid=0 before any next frame.
- Backpressure: same frame, tx_tready pattern 1,0,0,1,0,1,1 → tx_tdata/tx_tlast constant during low-ready cycles; output order 0x11..0x44 with no loss or duplication.
- Full/overflow (SIZE=16): write 15 bytes without btx_last, tx_tready=0 → btx_full=1 after the 15th; a 16th write is dropped and btx_overflow pulses once. The fallback starts SEND; raise tx_tready → 15 bytes out in order.
- Concurrency: frame A (3 bytes) transmitting while frame B's last byte is written on the same cycle as A's tlast handshake → btx_frames unchanged that cycle (1→1); B starts after the IFG_CYCLES gap.
- With TX_BUFFER_FRAME_CNT_EN: send 3 frames and trigger 2 overflows → tx_frame_cnt=3, tx_drop_cnt=2. Without the macro, the bench compiles without those ports.
